// File: rtl/mac_accum.sv
// mac_accum: sums frames of N_TERMS unsigned multiply-add results and
// presents one frame sum per frame on a valid/ready output.
// Optional feature macro: MAC_ACCUM_SAT_EN (clip the frame sum to
// SIZE_OUT bits and flag it on out_sat; otherwise the sum wraps).
module mac_accum #(
  parameter int SIZE_IN  = 16,
  parameter int N_TERMS  = 8,
  parameter int SIZE_OUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [SIZE_IN-1:0]  in_data,
  output logic                in_ready,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SIZE_OUT-1:0] out_data,
  output logic                out_sat
);

  localparam int CNT_W    = $clog2(N_TERMS);
  localparam int SIZE_ACC = SIZE_IN + CNT_W;

  logic [SIZE_ACC-1:0] r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_out_valid;
  logic [SIZE_OUT-1:0] r_out_data;
  logic                r_out_sat;

  logic                w_accept;
  logic                w_frame_end;
  logic [SIZE_ACC-1:0] w_sum;
  logic                w_clip;
  logic [SIZE_OUT-1:0] w_res_data;
  logic                w_res_sat;

  // Input handshake: stall while an output is pending and not taken,
  // and refuse beats during reset or flush.
  always_comb begin
    in_ready    = !reset && !flush && (!r_out_valid || out_ready);
    w_accept    = in_valid && in_ready;
    w_frame_end = w_accept && (r_cnt == CNT_W'(N_TERMS - 1));
    // Full-width sum; SIZE_ACC is sized so this can never overflow.
    w_sum       = r_acc + SIZE_ACC'(in_data);
    // Any bit above the output width means the sum does not fit.
    w_clip      = |(w_sum >> SIZE_OUT);
  end

`ifdef MAC_ACCUM_SAT_EN
  // Saturating result: clip to all-ones and flag it.
  always_comb begin
    w_res_data = w_clip ? '1 : SIZE_OUT'(w_sum);
    w_res_sat  = w_clip;
  end
`else
  logic w_clip_unused;
  // Wrapping result: keep the low bits, never flag.
  always_comb begin
    w_res_data    = SIZE_OUT'(w_sum);
    w_res_sat     = 1'b0;
    w_clip_unused = w_clip;
  end
`endif

  // Partial-frame accumulator and beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (flush || w_frame_end) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Output register: loads on frame end (even while being consumed, for
  // full throughput), clears valid when taken, otherwise holds stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_frame_end) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_res_data;
      r_out_sat   <= w_res_sat;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_mac_accum.sv
// Testbench for mac_accum: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a frame-level
// behavioural model.
module tb_mac_accum;
  localparam int SIZE_IN  = 16;
  localparam int N_TERMS  = 8;
  localparam int SIZE_OUT = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic [SIZE_IN-1:0]  in_data;
  logic                in_ready;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [SIZE_OUT-1:0] out_data;
  logic                out_sat;

  mac_accum #(.SIZE_IN(SIZE_IN), .N_TERMS(N_TERMS), .SIZE_OUT(SIZE_OUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: running frame sum, beats in frame, pending result.
  bit     m_started = 1'b0;
  bit     m_valid;
  longint m_data;
  bit     m_sat;
  longint m_psum;
  int     m_pcnt;
  bit     m_rdy;
  longint m_total;
  localparam longint MAXOUT = (longint'(1) << SIZE_OUT) - 1;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 0; m_data = 0; m_sat = 0; m_psum = 0; m_pcnt = 0;
      m_started = 1;
    end else if (m_started) begin
      m_rdy = !flush && (!m_valid || out_ready);
      if (flush) begin
        m_psum = 0; m_pcnt = 0;
        if (out_ready) m_valid = 0;
      end else if (in_valid && m_rdy && m_pcnt == N_TERMS - 1) begin
        m_total = m_psum + longint'(in_data);
        m_psum = 0; m_pcnt = 0;
        m_valid = 1;
`ifdef MAC_ACCUM_SAT_EN
        if (m_total > MAXOUT) begin m_data = MAXOUT; m_sat = 1; end
        else begin m_data = m_total; m_sat = 0; end
`else
        m_data = m_total % (MAXOUT + 1);
        m_sat  = 0;
`endif
      end else begin
        if (in_valid && m_rdy) begin
          m_psum += longint'(in_data);
          m_pcnt++;
        end
        if (out_ready) m_valid = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_started) begin
      check("in_ready",  in_ready,  !reset && !flush && (!m_valid || out_ready));
      check("out_valid", out_valid, m_valid);
      check("out_data",  out_data,  m_data);
      check("out_sat",   out_sat,   m_sat);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic beats(input int n, input logic [SIZE_IN-1:0] val);
    in_valid = 1; in_data = val;
    repeat (n) cycle();
    in_valid = 0;
  endtask

  task automatic expect_frame(input string name, input longint d, input bit s);
    check({name, "_valid"}, out_valid, 1);
    check({name, "_data"},  out_data,  d);
    check({name, "_sat"},   out_sat,   s);
    $display("frame %s: out_valid=%0d out_data=%0d out_sat=%0d", name, out_valid, out_data, out_sat);
  endtask

  longint stream_exp [3] = '{36, 100, 164};

  initial begin
    reset = 1; in_valid = 0; in_data = 0; flush = 0; out_ready = 1;
    repeat (2) cycle();
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    reset = 0;

    // Basic frame
    beats(8, 16'd1000);
    expect_frame("basic", 8000, 0);
    cycle();
    check("basic_valid_drop", out_valid, 0);

    // Saturation / wrap
    beats(8, 16'hFFFF);
`ifdef MAC_ACCUM_SAT_EN
    expect_frame("sat", 16'hFFFF, 1);
`else
    expect_frame("sat", 16'hFFF8, 0);
`endif
    cycle();

    // Backpressure
    out_ready = 0;
    beats(8, 16'd5);
    expect_frame("bp_first", 40, 0);
    in_valid = 1; in_data = 16'd7;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("bp_hold_data", out_data, 40);
      check("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1;
    repeat (8) cycle();
    in_valid = 0;
    expect_frame("bp_second", 56, 0);
    cycle();

    // Flush
    beats(3, 16'd500);
    flush = 1; in_valid = 1; in_data = 16'd500;
    #1;
    check("flush_in_ready", in_ready, 0);
    cycle();
    flush = 0; in_valid = 0;
    beats(8, 16'd10);
    expect_frame("flush", 80, 0);
    cycle();

    // Reset mid-frame, with a pending output held off by backpressure
    out_ready = 0;
    beats(8, 16'd3);
    out_ready = 1;
    beats(5, 16'd300);
    reset = 1;
    cycle();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 0);
    reset = 0;
    beats(8, 16'd2);
    expect_frame("rst", 16, 0);
    cycle();

    // Streaming at full throughput
    in_valid = 1;
    for (int i = 1; i <= 24; i++) begin
      in_data = SIZE_IN'(i);
      cycle();
      if (i % 8 == 0) expect_frame("stream", stream_exp[i / 8 - 1], 0);
      else check("stream_gap_valid", out_valid, 0);
    end
    in_valid = 0;
    cycle();

    // Randomized traffic, checked by the per-cycle model comparison
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : SIZE_IN'($urandom);
      cycle();
    end
    reset = 0; flush = 0; in_valid = 0; out_ready = 1;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
